// File: rtl/alu_pkg.sv
// Shared encodings for the ALU issue/control block: Sel codes, ALUOp/funct codes,
// FSM states and the decoded-operation record.
package alu_pkg;

    localparam logic [3:0] SEL_NONE = 4'b0000;
    localparam logic [3:0] SEL_ADD  = 4'b0001;
    localparam logic [3:0] SEL_SUB  = 4'b0010;
    localparam logic [3:0] SEL_MUL  = 4'b0011;
    localparam logic [3:0] SEL_DIV  = 4'b0100;
    localparam logic [3:0] SEL_AND  = 4'b0101;
    localparam logic [3:0] SEL_OR   = 4'b0110;
    localparam logic [3:0] SEL_NOR  = 4'b0111;
    localparam logic [3:0] SEL_SLT  = 4'b1000;
    localparam logic [3:0] SEL_XOR  = 4'b1001;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;
    localparam logic [1:0] ALUOP_ILL   = 2'b11;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_NOR = 6'b100111;
    localparam logic [5:0] FN_XOR = 6'b100110;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_MUL = 6'b011000;
    localparam logic [5:0] FN_DIV = 6'b011010;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_ITER = 2'b10,
        ST_DONE = 2'b11
    } state_t;

    typedef struct packed {
        logic [3:0] sel;
        logic       illegal;
        logic       muldiv;
        logic       is_div;
    } dec_t;

endpackage

// File: rtl/muldiv_iter.sv
// Iterative unsigned multiply (shift-add) / divide (restoring), one bit per cycle.
// done pulses during the last step; result is that step's outcome, valid with done.
module muldiv_iter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic         is_div,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] result
);

    localparam int CW = $clog2(W);

    logic [2*W-1:0] acc, acc_nxt;
    logic [W-1:0]   opnd;
    logic           div_q;
    logic [CW-1:0]  count;
    logic [W:0]     sum, rem, diff;
    logic           ge;

    // MUL: acc = {partial, multiplier}; DIV: acc = {remainder, dividend/quotient}
    always_comb begin
        sum  = {1'b0, acc[2*W-1:W]} + {1'b0, (acc[0] ? opnd : {W{1'b0}})};
        rem  = {acc[2*W-1:W], acc[W-1]};
        diff = rem - {1'b0, opnd};
        ge   = (rem >= {1'b0, opnd});
        if (div_q)
            acc_nxt = ge ? {diff[W-1:0], acc[W-2:0], 1'b1}
                         : {rem[W-1:0],  acc[W-2:0], 1'b0};
        else
            acc_nxt = {sum, acc[W-1:1]};
    end

    assign done   = busy && (count == CW'(W - 1));
    assign result = acc_nxt[W-1:0];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc   <= '0;
            opnd  <= '0;
            div_q <= 1'b0;
            count <= '0;
            busy  <= 1'b0;
        end else if (start) begin
            acc   <= {{W{1'b0}}, (is_div ? a : b)};
            opnd  <= is_div ? b : a;
            div_q <= is_div;
            count <= '0;
            busy  <= 1'b1;
        end else if (busy) begin
            acc   <= acc_nxt;
            count <= count + 1'b1;
            if (done)
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/alu_ctrl_seq.sv
// Issue/control side of the ALU Sel interface: decodes ALUOp/funct, drives the
// combinational ALU through registered Sel/operands, and runs MUL/DIV internally.
module alu_ctrl_seq
    import alu_pkg::*;
#(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [1:0]   ALUOp,
    input  logic [5:0]   funct,
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic [3:0]   Sel,
    output logic [W-1:0] alu_A,
    output logic [W-1:0] alu_B,
    input  logic [W-1:0] alu_res,
    input  logic         alu_zero,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] res_out,
    output logic         zero_out,
    output logic         illegal
);

    function automatic dec_t decode(input logic [1:0] op, input logic [5:0] fn);
        dec_t d;
        d = '{sel: SEL_NONE, illegal: 1'b0, muldiv: 1'b0, is_div: 1'b0};
        case (op)
            ALUOP_ADD: d.sel = SEL_ADD;
            ALUOP_SUB: d.sel = SEL_SUB;
            ALUOP_FUNCT: begin
                case (fn)
                    FN_ADD: d.sel = SEL_ADD;
                    FN_SUB: d.sel = SEL_SUB;
                    FN_AND: d.sel = SEL_AND;
                    FN_OR:  d.sel = SEL_OR;
                    FN_NOR: d.sel = SEL_NOR;
                    FN_XOR: d.sel = SEL_XOR;
                    FN_SLT: d.sel = SEL_SLT;
                    // MUL/DIV keep the ALU idle (Sel NONE) and use the local engine
                    FN_MUL: d.muldiv = 1'b1;
                    FN_DIV: begin
                        d.muldiv = 1'b1;
                        d.is_div = 1'b1;
                    end
                    default: d.illegal = 1'b1;
                endcase
            end
            default: d.illegal = 1'b1;
        endcase
        return d;
    endfunction

    state_t       state;
    dec_t         dec;
    logic         md_start, md_busy, md_done;
    logic [W-1:0] md_res;

    assign dec      = decode(ALUOp, funct);
    assign in_ready = (state == ST_IDLE);
    assign md_start = in_ready && in_valid && dec.muldiv && !md_busy;

    muldiv_iter #(.W(W)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .is_div (dec.is_div),
        .a      (A),
        .b      (B),
        .busy   (md_busy),
        .done   (md_done),
        .result (md_res)
    );

    // out_valid is raised the cycle after the result lands, so DONE's first
    // cycle only settles the output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            Sel       <= SEL_NONE;
            alu_A     <= '0;
            alu_B     <= '0;
            res_out   <= '0;
            zero_out  <= 1'b0;
            illegal   <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid) begin
                        alu_A   <= A;
                        alu_B   <= B;
                        Sel     <= dec.sel;
                        illegal <= dec.illegal;
                        state   <= dec.muldiv ? ST_ITER : ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    res_out  <= alu_res;
                    zero_out <= alu_zero;
                    state    <= ST_DONE;
                end
                ST_ITER: begin
                    if (md_done) begin
                        res_out  <= md_res;
                        zero_out <= (md_res == '0);
                        state    <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
